// File: rtl/ov5640_ddr_w_burst.sv
// Packs gated 24-bit camera pixels four to a 128-bit word, buffers them in a FIFO and writes
// fixed-length AXI4 INCR bursts into a rotating set of frame buffers.
module ov5640_ddr_w_burst #(
    parameter int          BURST_LEN  = 64,
    parameter int          FIFO_DEPTH = 512,
    parameter logic [31:0] FRAME_BASE = 32'h0000_0000,
    parameter logic [31:0] FRAME_SIZE = 32'h0040_0000,
    parameter int          FRAME_NUM  = 3
) (
    input  logic         axi_clk,
    input  logic         axi_rst_n,
    input  logic [23:0]  s_data,
    input  logic         s_data_valid,
    input  logic         s_vsync,
    output logic [31:0]  m_axi_awaddr,
    output logic [7:0]   m_axi_awlen,
    output logic [2:0]   m_axi_awsize,
    output logic [1:0]   m_axi_awburst,
    output logic         m_axi_awvalid,
    input  logic         m_axi_awready,
    output logic [127:0] m_axi_wdata,
    output logic [15:0]  m_axi_wstrb,
    output logic         m_axi_wlast,
    output logic         m_axi_wvalid,
    input  logic         m_axi_wready,
    input  logic [1:0]   m_axi_bresp,
    input  logic         m_axi_bvalid,
    output logic         m_axi_bready,
    output logic [1:0]   frame_idx,
    output logic         frame_done,
    output logic         ovf_err,
    output logic         resp_err
);
    localparam int          PW          = $clog2(FIFO_DEPTH);
    localparam int          LW          = PW + 1;
    localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN * 16);
    localparam logic [LW-1:0] LVL_BURST = LW'(BURST_LEN);
    localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);
    localparam logic [7:0]  BEAT_LAST   = 8'(BURST_LEN - 1);
    localparam logic [1:0]  IDX_LAST    = 2'(FRAME_NUM - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_AW    = 3'd1;
    localparam logic [2:0] S_W     = 3'd2;
    localparam logic [2:0] S_B     = 3'd3;
    localparam logic [2:0] S_FLUSH = 3'd4;

    logic [2:0]    state;
    logic [1:0]    pack_cnt;
    logic [127:0]  pack_q;
    logic          push_vld;
    logic [127:0]  mem [FIFO_DEPTH];
    logic [LW-1:0] wr_ptr, rd_ptr, level;
    logic          fifo_full, do_push, pop;
    logic [7:0]    beat;
    logic [31:0]   offset, next_off;
    logic [1:0]    wr_idx;
    logic          switch_pend, wrote;

    // A complete group sits in pack_q for one cycle while it is pushed; the next
    // group's first pixel may overwrite slot 0 on that same edge.
    always_ff @(posedge axi_clk or negedge axi_rst_n) begin
        if (!axi_rst_n) begin
            pack_cnt <= 2'd0;
            pack_q   <= '0;
            push_vld <= 1'b0;
        end else begin
            push_vld <= 1'b0;
            if (s_vsync) begin
                pack_cnt <= 2'd0;
            end else if (s_data_valid) begin
                pack_q[{pack_cnt, 5'd0} +: 32] <= {8'h00, s_data};
                pack_cnt <= pack_cnt + 2'd1;
                push_vld <= (pack_cnt == 2'd3);
            end
        end
    end

    assign level     = wr_ptr - rd_ptr;
    assign fifo_full = (level == LVL_FULL);
    assign do_push   = push_vld && !fifo_full && (state != S_FLUSH);
    assign pop       = m_axi_wvalid && m_axi_wready;

    always_ff @(posedge axi_clk) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= pack_q;
    end

    always_ff @(posedge axi_clk or negedge axi_rst_n) begin
        if (!axi_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (state == S_FLUSH) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + LW'(1);
            if (pop)     rd_ptr <= rd_ptr + LW'(1);
        end
    end

    assign next_off = offset + BURST_BYTES;

    always_ff @(posedge axi_clk or negedge axi_rst_n) begin
        if (!axi_rst_n) begin
            state        <= S_IDLE;
            beat         <= 8'd0;
            offset       <= 32'd0;
            wr_idx       <= 2'd0;
            switch_pend  <= 1'b0;
            wrote        <= 1'b0;
            m_axi_awaddr <= 32'd0;
            frame_idx    <= 2'd0;
            frame_done   <= 1'b0;
            ovf_err      <= 1'b0;
            resp_err     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (s_vsync) switch_pend <= 1'b1;
            if (push_vld && fifo_full && state != S_FLUSH) ovf_err <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (switch_pend) begin
                        state <= S_FLUSH;
                    end else if (level >= LVL_BURST) begin
                        state        <= S_AW;
                        m_axi_awaddr <= FRAME_BASE + 32'(wr_idx) * FRAME_SIZE + offset;
                    end
                end
                S_AW: begin
                    if (m_axi_awready) begin
                        state <= S_W;
                        beat  <= 8'd0;
                    end
                end
                S_W: begin
                    if (pop) begin
                        beat <= beat + 8'd1;
                        if (beat == BEAT_LAST) state <= S_B;
                    end
                end
                S_B: begin
                    if (m_axi_bvalid) begin
                        if (m_axi_bresp != 2'b00) resp_err <= 1'b1;
                        wrote <= 1'b1;
                        state <= S_IDLE;
                        // Running past the buffer end restarts at its base rather than
                        // spilling into the neighbouring frame.
                        if (next_off + BURST_BYTES > FRAME_SIZE) begin
                            offset  <= 32'd0;
                            ovf_err <= 1'b1;
                        end else begin
                            offset <= next_off;
                        end
                    end
                end
                S_FLUSH: begin
                    switch_pend <= 1'b0;
                    offset      <= 32'd0;
                    wrote       <= 1'b0;
                    state       <= S_IDLE;
                    // Empty frames keep their buffer so a stray vsync does not burn one.
                    if (wrote) begin
                        frame_done <= 1'b1;
                        frame_idx  <= wr_idx;
                        wr_idx     <= (wr_idx == IDX_LAST) ? 2'd0 : wr_idx + 2'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign m_axi_awlen   = BEAT_LAST;
    assign m_axi_awsize  = 3'b100;
    assign m_axi_awburst = 2'b01;
    assign m_axi_wstrb   = 16'hFFFF;
    assign m_axi_awvalid = (state == S_AW);
    assign m_axi_wvalid  = (state == S_W) && (level != '0);
    assign m_axi_wlast   = m_axi_wvalid && (beat == BEAT_LAST);
    assign m_axi_wdata   = m_axi_wvalid ? mem[rd_ptr[PW-1:0]] : '0;
    assign m_axi_bready  = (state == S_B);

endmodule

// File: tb/tb_ov5640_ddr_w_burst.sv
// Bench for ov5640_ddr_w_burst: randomized pixel streams against a queue-based frame/burst
// model, with a responsive AXI slave that records every handshake.
module tb_ov5640_ddr_w_burst;
    localparam int          BL    = 64;
    localparam int          FD    = 512;
    localparam int          FN    = 3;
    localparam logic [31:0] FBASE = 32'h0000_0000;
    localparam logic [31:0] FSIZE = 32'h0040_0000;

    logic         axi_clk = 1'b0;
    logic         axi_rst_n = 1'b0;
    logic [23:0]  s_data = '0;
    logic         s_data_valid = 1'b0;
    logic         s_vsync = 1'b0;
    logic [31:0]  m_axi_awaddr;
    logic [7:0]   m_axi_awlen;
    logic [2:0]   m_axi_awsize;
    logic [1:0]   m_axi_awburst;
    logic         m_axi_awvalid;
    logic         m_axi_awready = 1'b0;
    logic [127:0] m_axi_wdata;
    logic [15:0]  m_axi_wstrb;
    logic         m_axi_wlast;
    logic         m_axi_wvalid;
    logic         m_axi_wready = 1'b0;
    logic [1:0]   m_axi_bresp = 2'b00;
    logic         m_axi_bvalid = 1'b0;
    logic         m_axi_bready;
    logic [1:0]   frame_idx;
    logic         frame_done;
    logic         ovf_err;
    logic         resp_err;

    ov5640_ddr_w_burst #(
        .BURST_LEN(BL), .FIFO_DEPTH(FD), .FRAME_BASE(FBASE), .FRAME_SIZE(FSIZE), .FRAME_NUM(FN)
    ) dut (
        .axi_clk(axi_clk), .axi_rst_n(axi_rst_n),
        .s_data(s_data), .s_data_valid(s_data_valid), .s_vsync(s_vsync),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
        .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .frame_idx(frame_idx), .frame_done(frame_done), .ovf_err(ovf_err), .resp_err(resp_err)
    );

    always #5 axi_clk = ~axi_clk;

    int n_chk = 0;
    int n_fail = 0;

    // slave configuration and observation
    int          aw_delay = 0;
    int          w_prob = 100;
    logic [1:0]  bresp_cfg = 2'b00;
    int          aw_wait = 0, pend_b = 0;
    bit          b_fire = 1'b0, aw_pend_prev = 1'b0;
    logic [31:0] aw_prev_addr = '0;
    int          proto_err = 0, aw_unstable = 0, aws = 0, wlasts = 0, b_cnt = 0, w_beats = 0;
    logic [31:0]  aw_q[$];
    logic [127:0] w_q[$];
    bit           wl_q[$];
    logic [1:0]   done_q[$];

    // reference model: frame number, bursts in frame, pending pixel group and words
    logic [31:0]  m_grp[$];
    logic [127:0] m_fifo[$];
    logic [127:0] exp_w[$];
    logic [31:0]  exp_a[$];
    logic [1:0]   exp_done[$];
    int           m_frame = 0, m_bursts = 0;

    // Every handshake decided here completes on the following rising edge.
    always @(negedge axi_clk) begin
        if (!axi_rst_n) begin
            m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
            pend_b = 0; b_fire = 1'b0; aw_wait = 0; aw_pend_prev = 1'b0;
        end else begin
            if (aw_pend_prev && (!m_axi_awvalid || m_axi_awaddr !== aw_prev_addr)) aw_unstable++;
            m_axi_awready = m_axi_awvalid && (aw_wait >= aw_delay);
            m_axi_wready  = ($urandom_range(99) < w_prob);
            if (m_axi_awvalid && m_axi_wvalid) proto_err++;
            if (m_axi_awvalid && m_axi_awready) begin
                aw_q.push_back(m_axi_awaddr); aws++; aw_wait = 0;
            end else if (m_axi_awvalid) begin
                aw_wait++;
            end
            aw_pend_prev = m_axi_awvalid && !m_axi_awready;
            aw_prev_addr = m_axi_awaddr;
            if (b_fire) begin m_axi_bvalid = 1'b0; b_fire = 1'b0; b_cnt++; end
            if (!m_axi_bvalid && pend_b > 0) begin
                m_axi_bvalid = 1'b1; m_axi_bresp = bresp_cfg; pend_b--;
            end
            if (m_axi_bvalid && m_axi_bready) b_fire = 1'b1;
            if (m_axi_wvalid && m_axi_wready) begin
                if (aws <= wlasts) proto_err++;
                w_q.push_back(m_axi_wdata); wl_q.push_back(m_axi_wlast); w_beats++;
                if (m_axi_wlast) begin wlasts++; pend_b++; end
            end
            if (frame_done) done_q.push_back(frame_idx);
        end
    end

    function automatic void model_pixel(input logic [23:0] p);
        m_grp.push_back({8'h00, p});
        if (m_grp.size() == 4) begin
            m_fifo.push_back({m_grp[3], m_grp[2], m_grp[1], m_grp[0]});
            m_grp.delete();
            if (m_fifo.size() == BL) begin
                exp_a.push_back(FBASE + 32'(m_frame) * FSIZE + 32'(m_bursts) * 32'(BL * 16));
                foreach (m_fifo[i]) exp_w.push_back(m_fifo[i]);
                m_fifo.delete();
                m_bursts++;
            end
        end
    endfunction

    function automatic void model_vsync();
        m_grp.delete();
        m_fifo.delete();
        if (m_bursts > 0) begin
            exp_done.push_back(2'(m_frame));
            m_frame  = (m_frame + 1) % FN;
            m_bursts = 0;
        end
    endfunction

    function automatic int first_bad_addr();
        if (aw_q.size() != exp_a.size()) return (aw_q.size() < exp_a.size()) ? aw_q.size() : exp_a.size();
        foreach (exp_a[i]) if (aw_q[i] !== exp_a[i]) return i;
        return -1;
    endfunction

    function automatic int first_bad_word();
        if (w_q.size() != exp_w.size()) return (w_q.size() < exp_w.size()) ? w_q.size() : exp_w.size();
        foreach (exp_w[i]) if (w_q[i] !== exp_w[i]) return i;
        return -1;
    endfunction

    function automatic int first_bad_last();
        foreach (wl_q[i]) if (wl_q[i] !== ((i % BL) == BL - 1)) return i;
        return -1;
    endfunction

    task automatic clear_tb();
        s_data = '0; s_data_valid = 1'b0; s_vsync = 1'b0;
        aw_delay = 0; w_prob = 100; bresp_cfg = 2'b00;
        proto_err = 0; aw_unstable = 0; aws = 0; wlasts = 0; b_cnt = 0; w_beats = 0;
        aw_q.delete(); w_q.delete(); wl_q.delete(); done_q.delete();
        m_grp.delete(); m_fifo.delete(); exp_w.delete(); exp_a.delete(); exp_done.delete();
        m_frame = 0; m_bursts = 0;
    endtask

    task automatic do_reset();
        @(negedge axi_clk);
        axi_rst_n = 1'b0;
        clear_tb();
        repeat (3) @(negedge axi_clk);
        axi_rst_n = 1'b1;
        @(negedge axi_clk);
    endtask

    task automatic send_pixels(input int n, input bit seq, input int base, input int gap_pct);
        logic [23:0] p;
        for (int i = 0; i < n; i++) begin
            p = seq ? 24'(base + i) : 24'($urandom);
            while ($urandom_range(99) < gap_pct) begin
                @(negedge axi_clk); s_data_valid = 1'b0;
            end
            @(negedge axi_clk);
            s_data = p; s_data_valid = 1'b1;
            model_pixel(p);
        end
        @(negedge axi_clk);
        s_data_valid = 1'b0;
    endtask

    task automatic pulse_vsync();
        @(negedge axi_clk);
        s_vsync = 1'b1; s_data_valid = 1'b0;
        model_vsync();
        @(negedge axi_clk);
        s_vsync = 1'b0;
        repeat (4) @(negedge axi_clk);
    endtask

    task automatic wait_b(input int target);
        int cyc = 0;
        while (b_cnt < target && cyc < 4000) begin @(negedge axi_clk); cyc++; end
        repeat (2) @(negedge axi_clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready} !== 4'b0) begin
            n_fail++; $display("FAIL rst_valids: got %b want 0000", {m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready});
        end
        n_chk++;
        if (m_axi_awaddr !== 32'h0 || m_axi_wdata !== 128'h0) begin
            n_fail++; $display("FAIL rst_addr_data: got awaddr=%h wdata=%h want 0", m_axi_awaddr, m_axi_wdata);
        end
        n_chk++;
        if ({frame_idx, frame_done, ovf_err, resp_err} !== 5'b0) begin
            n_fail++; $display("FAIL rst_status: got %b want 00000", {frame_idx, frame_done, ovf_err, resp_err});
        end
        n_chk++;
        if (m_axi_awlen !== 8'd63 || m_axi_awsize !== 3'b100 || m_axi_awburst !== 2'b01 || m_axi_wstrb !== 16'hFFFF) begin
            n_fail++; $display("FAIL rst_const: got len=%0d size=%b burst=%b strb=%h want 63 100 01 ffff",
                               m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_wstrb);
        end
    endtask

    task automatic test_single_burst();
        int bad;
        pulse_vsync();
        send_pixels(256, 1'b1, 0, 0);
        wait_b(1);
        n_chk++;
        if (aw_q.size() != 1 || aw_q[0] !== 32'h0) begin
            n_fail++; $display("FAIL t1_awaddr: got %0d bursts first=%h want 1 burst at 0", aw_q.size(), aw_q.size() > 0 ? aw_q[0] : 32'h0);
        end
        n_chk++;
        if (w_q.size() == 0 || w_q[0] !== 128'h00000003_00000002_00000001_00000000) begin
            n_fail++; $display("FAIL t1_beat0: got %h want 00000003000000020000000100000000", w_q.size() > 0 ? w_q[0] : 128'h0);
        end
        bad = first_bad_last();
        n_chk++;
        if (bad >= 0 || wl_q.size() != BL) begin
            n_fail++; $display("FAIL t1_wlast: bad beat %0d of %0d, want wlast only on beat 63", bad, wl_q.size());
        end
        send_pixels(256, 1'b1, 256, 0);
        wait_b(2);
        n_chk++;
        if (aw_q.size() != 2 || aw_q[1] !== 32'h400) begin
            n_fail++; $display("FAIL t1_offset: got %0d bursts second=%h want 2 bursts, 400", aw_q.size(), aw_q.size() > 1 ? aw_q[1] : 32'h0);
        end
        bad = first_bad_word();
        n_chk++;
        if (bad >= 0) begin
            n_fail++; $display("FAIL t1_wdata: first bad beat %0d, beats got %0d want %0d", bad, w_q.size(), exp_w.size());
        end
    endtask

    task automatic test_backpressure();
        int bad;
        aw_delay = 20; w_prob = 50;
        send_pixels(256, 1'b0, 0, 30);
        wait_b(3);
        aw_delay = 0; w_prob = 100;
        n_chk++;
        if (aw_unstable != 0 || proto_err != 0) begin
            n_fail++; $display("FAIL t2_protocol: got unstable=%0d proto=%0d want 0 0", aw_unstable, proto_err);
        end
        bad = first_bad_addr();
        n_chk++;
        if (bad >= 0 || aw_q[2] !== 32'h800) begin
            n_fail++; $display("FAIL t2_awaddr: first bad %0d, got %0d bursts want %0d (third at 800)", bad, aw_q.size(), exp_a.size());
        end
        bad = first_bad_word();
        n_chk++;
        if (bad >= 0) begin
            n_fail++; $display("FAIL t2_wdata: first bad beat %0d, beats got %0d want %0d", bad, w_q.size(), exp_w.size());
        end
        bad = first_bad_last();
        n_chk++;
        if (bad >= 0) begin
            n_fail++; $display("FAIL t2_wlast: bad beat %0d", bad);
        end
    endtask

    task automatic test_frame_rotation();
        int bad;
        do_reset();
        for (int f = 0; f < 4; f++) begin
            send_pixels(256, 1'b0, 0, 10);
            wait_b(f + 1);
            if (f < 3) pulse_vsync();
        end
        bad = first_bad_addr();
        n_chk++;
        if (bad >= 0 || aw_q.size() != 4 || aw_q[1] !== 32'h0040_0000 || aw_q[2] !== 32'h0080_0000 || aw_q[3] !== 32'h0) begin
            n_fail++; $display("FAIL t3_awaddr: first bad %0d, got %0d bursts want 4 at 0,400000,800000,0", bad, aw_q.size());
        end
        n_chk++;
        if (done_q.size() != 3 || done_q[0] !== 2'd0 || done_q[1] !== 2'd1 || done_q[2] !== 2'd2) begin
            n_fail++; $display("FAIL t3_frame_done: got %0d pulses want 3 with idx 0,1,2", done_q.size());
        end
        bad = first_bad_word();
        n_chk++;
        if (bad >= 0) begin
            n_fail++; $display("FAIL t3_wdata: first bad beat %0d, beats got %0d want %0d", bad, w_q.size(), exp_w.size());
        end
    endtask

    task automatic test_vsync_mid_burst();
        int bad, cyc;
        do_reset();
        send_pixels(256, 1'b0, 0, 0);
        wait_b(1);
        w_prob = 50;
        send_pixels(256, 1'b0, 0, 0);
        cyc = 0;
        while (w_beats < BL + 30 && cyc < 2000) begin @(negedge axi_clk); cyc++; end
        pulse_vsync();
        wait_b(2);
        w_prob = 100;
        send_pixels(256, 1'b0, 0, 0);
        wait_b(3);
        bad = first_bad_addr();
        n_chk++;
        if (bad >= 0 || aw_q.size() != 3 || aw_q[1] !== 32'h400 || aw_q[2] !== 32'h0040_0000) begin
            n_fail++; $display("FAIL t4_awaddr: first bad %0d, got %0d bursts want 0,400,400000", bad, aw_q.size());
        end
        bad = first_bad_word();
        n_chk++;
        if (bad >= 0) begin
            n_fail++; $display("FAIL t4_wdata: first bad beat %0d, beats got %0d want %0d", bad, w_q.size(), exp_w.size());
        end
        n_chk++;
        if (done_q.size() != exp_done.size() || done_q.size() != 1 || done_q[0] !== 2'd0) begin
            n_fail++; $display("FAIL t4_frame_done: got %0d pulses want 1 with idx 0", done_q.size());
        end
    endtask

    task automatic test_errors();
        do_reset();
        w_prob = 0;
        send_pixels(4 * FD + 8, 1'b0, 0, 0);
        repeat (4) @(negedge axi_clk);
        n_chk++;
        if (ovf_err !== 1'b1 || resp_err !== 1'b0) begin
            n_fail++; $display("FAIL t5_overflow: got ovf=%b resp=%b want 1 0", ovf_err, resp_err);
        end
        bresp_cfg = 2'b10; w_prob = 100;
        wait_b(FD / BL);
        n_chk++;
        if (resp_err !== 1'b1 || aws != FD / BL) begin
            n_fail++; $display("FAIL t5_resp_err: got resp=%b bursts=%0d want 1 %0d", resp_err, aws, FD / BL);
        end
        bresp_cfg = 2'b00;
    endtask

    task automatic test_reset_mid_burst();
        int bad, cyc;
        do_reset();
        w_prob = 50;
        send_pixels(256, 1'b0, 0, 0);
        cyc = 0;
        while (w_beats < 10 && cyc < 2000) begin @(negedge axi_clk); cyc++; end
        axi_rst_n = 1'b0;
        #1;
        n_chk++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready} !== 4'b0 || m_axi_wdata !== 128'h0 || m_axi_awaddr !== 32'h0) begin
            n_fail++; $display("FAIL t6_axi_drop: got valids=%b wdata=%h awaddr=%h want all 0",
                               {m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready}, m_axi_wdata, m_axi_awaddr);
        end
        n_chk++;
        if ({frame_idx, frame_done, ovf_err, resp_err} !== 5'b0) begin
            n_fail++; $display("FAIL t6_status: got %b want 00000", {frame_idx, frame_done, ovf_err, resp_err});
        end
        clear_tb();
        repeat (3) @(negedge axi_clk);
        axi_rst_n = 1'b1;
        @(negedge axi_clk);
        send_pixels(256, 1'b1, 0, 0);
        wait_b(1);
        n_chk++;
        if (aw_q.size() != 1 || aw_q[0] !== 32'h0 || w_q.size() == 0 || w_q[0] !== 128'h00000003_00000002_00000001_00000000) begin
            n_fail++; $display("FAIL t6_restart: got %0d bursts first addr=%h want 1 at 0 with clean beat0", aw_q.size(), aw_q.size() > 0 ? aw_q[0] : 32'h0);
        end
        bad = first_bad_word();
        n_chk++;
        if (bad >= 0) begin
            n_fail++; $display("FAIL t6_wdata: first bad beat %0d, beats got %0d want %0d", bad, w_q.size(), exp_w.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_backpressure();
        test_frame_rotation();
        test_vsync_mid_burst();
        test_errors();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
